output_port_arbiter: RTL and testbench

- Sits directly downstream of the five per-input routing units. One instance sits on each output direction (N, W, S, E, B) of a node.
- Collects the route request bit for its own direction from all five input ports and picks one winner per cycle. Arbitration is QoS-aware round-robin with anti-starvation.
- Pops the winner's input buffer through a one-hot grant.
- Launches the packet through a registered valid/ready output stage toward the link or the local sink.

---
 rtl/noc_pkg.sv | 26 ++
 rtl/rr_pick5.sv | 40 ++++
 rtl/output_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_output_port_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC constants, packet field layout and packet type
//
// Purpose: shared by the routing units and the output port arbiters.
// Packet layout (PKT_W = 23):
//   [22:21] type, [20:15] source, [14:9] target, [8] QoS, [7:0] payload
package noc_pkg;

  localparam int NUM_DIR = 5;
  localparam int DIR_N   = 0;
  localparam int DIR_W   = 1;
  localparam int DIR_S   = 2;
  localparam int DIR_E   = 3;
  localparam int DIR_B   = 4;

  localparam int PKT_W    = 23;
  localparam int TYPE_LSB = 21;
  localparam int TYPE_W   = 2;
  localparam int SRC_LSB  = 15;
  localparam int SRC_W    = 6;
  localparam int TGT_LSB  = 9;
  localparam int TGT_W    = 6;
  localparam int QOS_POS  = 8;

  typedef logic [PKT_W-1:0] pkt_t;

endpackage

// File: rtl/rr_pick5.sv
// rtl/rr_pick5.sv - five-way round-robin picker starting at a pointer
//
// Purpose: combinational first-requester search over indices ptr, ptr+1, ...
// wrapping modulo NUM_DIR.
// Ports:
//   req_i   [4:0]  request vector
//   ptr_i   [2:0]  search start index (always < NUM_DIR)
//   gnt_o   [4:0]  one-hot grant, zero when nothing requests
//   found_o        at least one request was present
module rr_pick5
  import noc_pkg::*;
(
  input  logic [NUM_DIR-1:0] req_i,
  input  logic [2:0]         ptr_i,
  output logic [NUM_DIR-1:0] gnt_o,
  output logic               found_o
);

  logic [3:0] idx;
  logic       found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_DIR; k++) begin
      // ptr + k is at most 8, so a single conditional subtract wraps it
      idx = {1'b0, ptr_i} + 4'(k);
      if (idx >= 4'(NUM_DIR)) begin
        idx = idx - 4'(NUM_DIR);
      end
      if (!found && req_i[idx[2:0]]) begin
        gnt_o[idx[2:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    found_o = found;
  end

endmodule

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - QoS round-robin output port arbiter with anti-starvation
//
// Purpose: one instance per output direction of a node. Picks one of the
// five input ports per cycle (high QoS class first, round-robin within a
// class, low class forced after STARVE_LIMIT consecutive high grants while
// low requests wait), pops the winner with a one-hot grant and registers
// the packet into a valid/ready output stage.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_in          per-input request for this direction
//   pkt_in          packed input packets, input i at [i*PKT_W +: PKT_W]
//   port_disable    blocks all grants (faulty neighbour / mesh edge)
//   grant_out       one-hot pop strobe, combinational
//   out_valid       output register holds a packet
//   out_pkt         registered packet
//   out_ready       downstream accept
module output_port_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_IN       = noc_pkg::NUM_DIR,
  parameter int PKT_W        = noc_pkg::PKT_W,
  parameter int QOS_POS      = noc_pkg::QOS_POS,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       req_in,
  input  logic [NUM_IN*PKT_W-1:0] pkt_in,
  input  logic                    port_disable,
  output logic [NUM_IN-1:0]       grant_out,
  output logic                    out_valid,
  output logic [PKT_W-1:0]        out_pkt,
  input  logic                    out_ready
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [2:0]        hi_ptr_q, hi_ptr_d;
  logic [2:0]        lo_ptr_q, lo_ptr_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              out_valid_q, out_valid_d;
  logic [PKT_W-1:0]  out_pkt_q, out_pkt_d;

  logic [NUM_IN-1:0] hi_req, lo_req;
  logic [NUM_IN-1:0] hi_gnt, lo_gnt;
  logic              hi_found, lo_found;
  logic              slot_free, grant_en, sel_lo, any_grant;
  logic [NUM_IN-1:0] grant;
  logic [2:0]        win_idx, next_ptr;
  logic [PKT_W-1:0]  win_pkt;

  always_comb begin
    hi_req = '0;
    lo_req = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (req_in[i]) begin
        if (pkt_in[i*PKT_W + QOS_POS]) hi_req[i] = 1'b1;
        else                           lo_req[i] = 1'b1;
      end
    end
  end

  rr_pick5 u_pick_hi (
    .req_i   (hi_req),
    .ptr_i   (hi_ptr_q),
    .gnt_o   (hi_gnt),
    .found_o (hi_found)
  );

  rr_pick5 u_pick_lo (
    .req_i   (lo_req),
    .ptr_i   (lo_ptr_q),
    .gnt_o   (lo_gnt),
    .found_o (lo_found)
  );

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    // rst gates the grant so upstream buffers are never popped during reset
    grant_en  = slot_free && !port_disable && !rst;
    sel_lo    = ((starve_q == LIMIT) && (|lo_req)) || (hi_req == '0);
    any_grant = grant_en && (sel_lo ? lo_found : hi_found);
    grant     = '0;
    if (any_grant) begin
      grant = sel_lo ? lo_gnt : hi_gnt;
    end

    win_idx = '0;
    win_pkt = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        win_idx = 3'(i);
        win_pkt = pkt_in[i*PKT_W +: PKT_W];
      end
    end
    next_ptr = (win_idx == 3'(NUM_IN - 1)) ? 3'd0 : win_idx + 3'd1;

    hi_ptr_d    = hi_ptr_q;
    lo_ptr_d    = lo_ptr_q;
    starve_d    = starve_q;
    out_valid_d = out_valid_q;
    out_pkt_d   = out_pkt_q;

    if (any_grant) begin
      out_pkt_d   = win_pkt;
      out_valid_d = 1'b1;
      if (sel_lo) begin
        lo_ptr_d = next_ptr;
        starve_d = '0;
      end else begin
        hi_ptr_d = next_ptr;
        if (|lo_req) begin
          starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
        end else begin
          starve_d = '0;
        end
      end
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      // a disabled port freezes its arbitration state entirely
      if (!port_disable && (lo_req == '0)) begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_ptr_q    <= '0;
      lo_ptr_q    <= '0;
      starve_q    <= '0;
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
    end else begin
      hi_ptr_q    <= hi_ptr_d;
      lo_ptr_q    <= lo_ptr_d;
      starve_q    <= starve_d;
      out_valid_q <= out_valid_d;
      out_pkt_q   <= out_pkt_d;
    end
  end

  assign grant_out = grant;
  assign out_valid = out_valid_q;
  assign out_pkt   = out_pkt_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb/tb_output_port_arbiter.sv - self-checking bench for output_port_arbiter
module tb_output_port_arbiter;

  localparam int N   = 5;
  localparam int W   = 23;
  localparam int Q   = 8;
  localparam int LIM = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_in;
  logic [N*W-1:0] pkt_in;
  logic           port_disable;
  logic [N-1:0]   grant_out;
  logic           out_valid;
  logic [W-1:0]   out_pkt;
  logic           out_ready;
  logic [W-1:0]   pk [N];

  always #5 clk = ~clk;

  always_comb begin
    pkt_in = '0;
    for (int i = 0; i < N; i++) pkt_in[i*W +: W] = pk[i];
  end

  output_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_in       (req_in),
    .pkt_in       (pkt_in),
    .port_disable (port_disable),
    .grant_out    (grant_out),
    .out_valid    (out_valid),
    .out_pkt      (out_pkt),
    .out_ready    (out_ready)
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  int           m_hi, m_lo, m_st;
  logic         m_v;
  logic [W-1:0] m_pkt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit lo_any();
    for (int i = 0; i < N; i++) if (req_in[i] && !pk[i][Q]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit hi_any();
    for (int i = 0; i < N; i++) if (req_in[i] && pk[i][Q]) return 1'b1;
    return 1'b0;
  endfunction

  // winner index from the arbitration rules, -1 when no grant
  function automatic int model_pick(output logic [N-1:0] g);
    bit use_lo;
    int ptr, j;
    g = '0;
    if (rst || port_disable || (m_v && !out_ready)) return -1;
    use_lo = ((m_st == LIM) && lo_any()) || !hi_any();
    ptr    = use_lo ? m_lo : m_hi;
    for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (req_in[j] && (pk[j][Q] == !use_lo)) begin
        g[j] = 1'b1;
        return j;
      end
    end
    return -1;
  endfunction

  task automatic model_update(input int w);
    if (rst) begin
      m_hi = 0; m_lo = 0; m_st = 0; m_v = 1'b0; m_pkt = '0;
    end else if (w >= 0) begin
      m_pkt = pk[w];
      m_v   = 1'b1;
      if (!pk[w][Q]) begin
        m_lo = (w + 1) % N;
        m_st = 0;
      end else begin
        m_hi = (w + 1) % N;
        m_st = lo_any() ? ((m_st + 1 > LIM) ? LIM : m_st + 1) : 0;
      end
    end else begin
      if (m_v && out_ready) m_v = 1'b0;
      if (!port_disable && !lo_any()) m_st = 0;
    end
  endtask

  // one clock: compare at negedge, advance the model at posedge, return 1 after it
  task automatic step(input string tag, output logic [N-1:0] g_seen,
                      output logic v_seen, output logic [W-1:0] p_seen);
    logic [N-1:0] eg;
    int w;
    @(negedge clk);
    w      = model_pick(eg);
    g_seen = grant_out;
    v_seen = out_valid;
    p_seen = out_pkt;
    check({tag, " grant"}, 32'(grant_out), 32'(eg));
    check({tag, " out_valid"}, 32'(out_valid), 32'(m_v));
    check({tag, " out_pkt"}, 32'(out_pkt), 32'(m_pkt));
    @(posedge clk);
    model_update(w);
    #1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] qos;
    logic [N-1:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [N-1:0] g;
    logic         v;
    logic [W-1:0] p;
    int           lo_save;

    rst = 1'b1; req_in = '0; port_disable = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) pk[i] = '0;
    m_hi = 0; m_lo = 0; m_st = 0; m_v = 1'b0; m_pkt = '0;

    // reset and idle
    step("rst0", g, v, p);
    step("rst1", g, v, p);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step("idle", g, v, p);
      check("idle no grant", 32'(g), 32'd0);
      check("idle out_valid", 32'(v), 32'd0);
    end

    // round-robin among low class, then QoS priority with anti-starvation
    tbl[0]  = '{5'b11111, 5'b00000, 5'b00001};
    tbl[1]  = '{5'b11111, 5'b00000, 5'b00010};
    tbl[2]  = '{5'b11111, 5'b00000, 5'b00100};
    tbl[3]  = '{5'b11111, 5'b00000, 5'b01000};
    tbl[4]  = '{5'b11111, 5'b00000, 5'b10000};
    tbl[5]  = '{5'b11111, 5'b00000, 5'b00001};
    tbl[6]  = '{5'b10101, 5'b00101, 5'b00001};
    tbl[7]  = '{5'b10101, 5'b00101, 5'b00100};
    tbl[8]  = '{5'b10101, 5'b00101, 5'b00001};
    tbl[9]  = '{5'b10101, 5'b00101, 5'b00100};
    tbl[10] = '{5'b10101, 5'b00101, 5'b10000};
    tbl[11] = '{5'b10101, 5'b00101, 5'b00001};
    for (int k = 0; k < 12; k++) begin
      req_in = tbl[k].req;
      for (int i = 0; i < N; i++) begin
        pk[i]    = 23'(i * 23'h11111 + 23'h3 + k);
        pk[i][Q] = tbl[k].qos[i];
      end
      step("tbl", g, v, p);
      check($sformatf("tbl%0d grant", k), 32'(g), 32'(tbl[k].exp));
    end

    // backpressure
    rst = 1'b1; req_in = '0;
    step("bp rst", g, v, p);
    rst = 1'b0;
    pk[0] = 23'h1A5A5A; pk[1] = 23'h0ABCDE;
    req_in = 5'b00001;
    step("bp first", g, v, p);
    check("bp first grant", 32'(g), 32'h01);
    req_in = 5'b00010; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step("bp hold", g, v, p);
      check("bp hold grant", 32'(g), 32'h00);
      check("bp hold valid", 32'(v), 32'h1);
      check("bp hold pkt", 32'(p), 32'h1A5A5A);
    end
    out_ready = 1'b1;
    step("bp release", g, v, p);
    check("bp release grant", 32'(g), 32'h02);
    req_in = '0;
    step("bp next", g, v, p);
    check("bp next pkt", 32'(p), 32'h0ABCDE);

    // port_disable
    pk[2] = 23'h055055;
    pk[2][Q] = 1'b0;
    req_in = 5'b00100; port_disable = 1'b1;
    lo_save = m_lo;
    for (int c = 0; c < 4; c++) begin
      step("dis", g, v, p);
      check("dis grant", 32'(g), 32'h00);
      check("dis lo_ptr", 32'(dut.lo_ptr_q), 32'(lo_save));
    end
    port_disable = 1'b0;
    step("dis off", g, v, p);
    check("dis off grant", 32'(g), 32'h04);

    // reset mid-transfer
    req_in = 5'b00001; pk[0] = 23'h1FFFFF;
    step("mid load", g, v, p);
    out_ready = 1'b0; req_in = '0;
    step("mid hold", g, v, p);
    check("mid hold valid", 32'(v), 32'h1);
    rst = 1'b1; out_ready = 1'b1; req_in = 5'b11111;
    step("mid rst", g, v, p);
    check("mid rst grant", 32'(g), 32'h00);
    rst = 1'b0; req_in = '0;
    check("mid out_valid", 32'(out_valid), 32'h0);
    check("mid hi_ptr", 32'(dut.hi_ptr_q), 32'h0);
    check("mid lo_ptr", 32'(dut.lo_ptr_q), 32'h0);
    check("mid starve", 32'(dut.starve_q), 32'h0);

    // randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      rst          = ($urandom_range(0, 99) < 2);
      port_disable = ($urandom_range(0, 99) < 10);
      out_ready    = ($urandom_range(0, 99) < 70);
      req_in       = 5'($urandom);
      for (int i = 0; i < N; i++) pk[i] = 23'($urandom);
      step("rand", g, v, p);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
